// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared FSM state encoding and default code width for controller, CPU FSM and benches
package interrupt_controller_pkg;
  localparam int CODE_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10} irq_state_e;
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: CPU-side bundle; master (CPU) drives irq_enable/irq_ack/irq_done, slave (controller) drives irq/irq_code/irq_active/pending/overflow
interface interrupt_controller_if #(parameter int CODE_W = interrupt_controller_pkg::CODE_W_DEF);
  logic irq_enable, irq_ack, irq_done, irq, irq_active, pending, overflow;
  logic [CODE_W-1:0] irq_code;
  modport master(output irq_enable, irq_ack, irq_done, input irq, irq_code, irq_active, pending, overflow);
  modport slave(input irq_enable, irq_ack, irq_done, output irq, irq_code, irq_active, pending, overflow);
endinterface

// File: rtl/interrupt_controller_key_debounce.sv
// key_debounce: two-flop synchronizer, debounce counter and one-cycle press pulse (clk, reset, key_n_i raw active-low button -> press_evt_o); presses are armed only after a released key is seen post-reset
module key_debounce #(parameter int DEBOUNCE_CYCLES = 1) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_evt_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1_q, sync2_q, db_q, armed_q, press_q, hit;
  logic [1:0] warm_q;
  logic [CW-1:0] cnt_q;
  assign hit = sync2_q != db_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q <= 1'b1;
      cnt_q <= '0;
      warm_q <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      cnt_q <= (sync2_q == db_q || hit) ? '0 : cnt_q + 1'b1;
      db_q <= hit ? sync2_q : db_q;
      warm_q <= {warm_q[0], 1'b1};
      armed_q <= armed_q | (warm_q[1] & sync2_q & db_q);
      press_q <= hit & ~sync2_q & armed_q;
    end
  assign press_evt_o = press_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: debounced key press -> CPU interrupt request with one-deep queue (clk, reset, key_n, sw_code in; bus: irq_enable/irq_ack/irq_done in, irq/irq_code/irq_active/pending/overflow out)
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CODE_W = CODE_W_DEF
) (
  input logic clk,
  input logic reset,
  input logic key_n,
  input logic [CODE_W-1:0] sw_code,
  interrupt_controller_if.slave bus
);
  irq_state_e state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, qcode_q, qcode_d;
  logic pend_q, pend_d, ovf_q, ovf_d, press, irq, ack_fire, done_fire;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .reset(reset),
    .key_n_i(key_n),
    .press_evt_o(press)
  );
  assign irq = state_q == REQ && bus.irq_enable;
  assign ack_fire = irq && bus.irq_ack;
  assign done_fire = state_q == SERVICE && bus.irq_done;
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    qcode_d = qcode_q;
    pend_d = pend_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      state_d = press ? REQ : IDLE;
      code_d = press ? sw_code : code_q;
    end else if (done_fire) begin
      state_d = (pend_q || press) ? REQ : IDLE;
      code_d = pend_q ? qcode_q : press ? sw_code : code_q;
      qcode_d = (pend_q && press) ? sw_code : qcode_q;
      pend_d = pend_q && press;
    end else begin
      state_d = ack_fire ? SERVICE : state_q;
      qcode_d = (press && !pend_q) ? sw_code : qcode_q;
      pend_d = pend_q || press;
      ovf_d = ovf_q || (press && pend_q);
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      code_q <= '0;
      qcode_q <= '0;
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      qcode_q <= qcode_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  assign bus.irq = irq;
  assign bus.irq_code = code_q;
  assign bus.irq_active = state_q == SERVICE;
  assign bus.pending = pend_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: randomized and directed stimulus against a queue-based reference model with a per-cycle scoreboard
module tb_interrupt_controller;
  localparam int D = 4;
  localparam int W = 8;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  typedef struct packed {
    logic irq;
    logic [W-1:0] code;
    logic active;
    logic pend;
    logic ovf;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, key_n = 1'b1;
  logic [W-1:0] sw_code = '0;
  interrupt_controller_if #(.CODE_W(W)) bus ();
  interrupt_controller #(.DEBOUNCE_CYCLES(D), .CODE_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw_code(sw_code),
    .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int checks = 0, errors = 0;
  string tag = "reset";
  bit k_v = 1, en_v = 1, ack_v = 0, done_v = 0, rst_v = 0;
  logic [W-1:0] s_v = '0;
  bit hist[$];
  bit db, armed, press;
  int since, st;
  logic [W-1:0] code;
  logic [W-1:0] q[$];
  bit ovf;
  task automatic model_reset();
    hist = '{1'b1, 1'b1};
    db = 1; armed = 0; press = 0; since = 0;
    st = M_IDLE; code = '0; q.delete(); ovf = 0;
  endtask
  task automatic model_edge();
    bit p, flip, done_now, ack_now;
    int n, st0;
    if (reset) begin
      model_reset();
      return;
    end
    p = press;
    st0 = st;
    done_now = st == M_SVC && bus.irq_done;
    ack_now = st == M_REQ && bus.irq_enable && bus.irq_ack;
    if (st0 == M_IDLE) begin
      if (p) begin st = M_REQ; code = sw_code; end
    end else begin
      if (done_now) begin
        if (q.size() != 0) begin code = q.pop_front(); st = M_REQ; end
        else if (p) begin code = sw_code; st = M_REQ; p = 0; end
        else st = M_IDLE;
      end
      if (ack_now) st = M_SVC;
      if (p) begin
        if (q.size() == 0) q.push_back(sw_code);
        else ovf = 1;
      end
    end
    since++;
    hist.push_back(key_n);
    n = hist.size();
    flip = n >= D + 2;
    if (flip) for (int i = n - 2 - D; i < n - 2; i++) if (hist[i] == db) flip = 0;
    press = flip && db && armed;
    if (since >= 3 && hist[n-3] && db) armed = 1;
    if (flip) db = !db;
    if (hist.size() > 64) void'(hist.pop_front());
  endtask
  task automatic tick();
    exp_t e;
    key_n = k_v; sw_code = s_v; reset = rst_v;
    bus.irq_enable = en_v; bus.irq_ack = ack_v; bus.irq_done = done_v;
    e.irq = st == M_REQ && en_v;
    e.code = code;
    e.active = st == M_SVC;
    e.pend = q.size() != 0;
    e.ovf = ovf;
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #2;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic press_key(input logic [W-1:0] c, input int len);
    s_v = c; k_v = 0; run(len);
    k_v = 1; run(D + 4);
  endtask
  task automatic pulse_ack();
    ack_v = 1; run(1); ack_v = 0; run(1);
  endtask
  task automatic pulse_done();
    done_v = 1; run(1); done_v = 0; run(1);
  endtask
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        g.irq = bus.irq; g.code = bus.irq_code; g.active = bus.irq_active;
        g.pend = bus.pending; g.ovf = bus.overflow;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s t=%0t got irq=%b code=%h act=%b pend=%b ovf=%b want irq=%b code=%h act=%b pend=%b ovf=%b",
                   tag, $time, g.irq, g.code, g.active, g.pend, g.ovf, e.irq, e.code, e.active, e.pend, e.ovf);
        end
      end
    end
  end
  initial begin
    bus.irq_enable = 1; bus.irq_ack = 0; bus.irq_done = 0;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    tag = "post_reset"; run(6);
    tag = "single"; press_key(8'h01, 8); pulse_ack(); run(2); pulse_done(); run(2);
    tag = "glitch"; press_key(8'h11, 2); run(4);
    press_key(8'h12, 6); pulse_ack(); pulse_done();
    tag = "queue"; press_key(8'h01, 8); pulse_ack();
    press_key(8'h02, 8); press_key(8'h03, 8);
    pulse_done(); pulse_ack(); pulse_done(); run(3);
    tag = "disabled"; en_v = 0; press_key(8'h05, 8); run(3);
    en_v = 1; run(1); pulse_ack(); pulse_done();
    tag = "press_done"; press_key(8'h01, 8); pulse_ack();
    s_v = 8'h07; k_v = 0; run(6); done_v = 1; run(1); done_v = 0; run(2);
    k_v = 1; run(D + 4); pulse_ack(); pulse_done();
    tag = "press_done_pend"; press_key(8'h21, 8); pulse_ack(); press_key(8'h22, 8);
    s_v = 8'h23; k_v = 0; run(6); done_v = 1; run(1); done_v = 0; k_v = 1; run(D + 4);
    pulse_ack(); pulse_done(); pulse_ack(); pulse_done();
    tag = "press_ack"; press_key(8'h31, 8);
    s_v = 8'h32; k_v = 0; run(6); ack_v = 1; run(1); ack_v = 0; k_v = 1; run(D + 4);
    pulse_done(); pulse_ack(); pulse_done();
    tag = "reset_mid"; press_key(8'h01, 8); pulse_ack(); press_key(8'h02, 8);
    k_v = 0; run(3); rst_v = 1; run(2); rst_v = 0; run(20);
    k_v = 1; run(D + 4); press_key(8'h44, 8); pulse_ack(); pulse_done();
    tag = "random";
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      k_v = $urandom_range(0, 1);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        s_v = W'($urandom);
        en_v = $urandom_range(0, 3) != 0;
        ack_v = $urandom_range(0, 9) < 3;
        done_v = $urandom_range(0, 9) < 2;
        rst_v = $urandom_range(0, 399) == 0;
        tick();
      end
    end
    rst_v = 0; ack_v = 0; done_v = 0; k_v = 1;
    run(4);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
